// File: rtl/bus_dma.sv
// bus_dma: single-channel memory-to-memory copy engine mastering one port of the shared bus.
// Bus outputs are flopped from the next-state decode, so they behave as Moore outputs of the state.
module bus_dma (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [7:0]  src_addr,
   input  logic [7:0]  dst_addr,
   input  logic [7:0]  length,
   input  logic        M_grant,
   input  logic [31:0] M_din,
   output logic        M_req,
   output logic        M_wr,
   output logic [7:0]  M_address,
   output logic [31:0] M_dout,
   output logic        busy,
   output logic        done,
   output logic [7:0]  words_done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  src_ptr_q, src_ptr_d;
   logic [7:0]  dst_ptr_q, dst_ptr_d;
   logic [7:0]  remain_q, remain_d;
   logic [7:0]  words_done_q, words_done_d;
   logic [31:0] data_q, data_d;

   logic        m_req_q, m_req_d;
   logic        m_wr_q, m_wr_d;
   logic [7:0]  m_address_q, m_address_d;
   logic [31:0] m_dout_q, m_dout_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;

   // Next-state and datapath register update.
   always_comb begin
      state_d      = state_q;
      src_ptr_d    = src_ptr_q;
      dst_ptr_d    = dst_ptr_q;
      remain_d     = remain_q;
      words_done_d = words_done_q;
      data_d       = data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               src_ptr_d    = src_addr;
               dst_ptr_d    = dst_addr;
               remain_d     = length;
               words_done_d = 8'd0;
               state_d      = (length == 8'd0) ? S_DONE : S_RD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RD: begin
            if (M_grant) begin
               state_d = S_CAP;
            end else begin
               state_d = S_RD;
            end
         end
         S_CAP: begin
            // Read data arrives one cycle after the granted address cycle, regardless of grant now.
            data_d    = M_din;
            src_ptr_d = src_ptr_q + 8'd1;
            state_d   = S_WR;
         end
         S_WR: begin
            if (M_grant) begin
               dst_ptr_d    = dst_ptr_q + 8'd1;
               remain_d     = (remain_q != 8'd0) ? (remain_q - 8'd1) : 8'd0;
               words_done_d = words_done_q + 8'd1;
               state_d      = (remain_q <= 8'd1) ? S_DONE : S_RD;
            end else begin
               state_d = S_WR;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so the flopped outputs match that state.
   always_comb begin
      m_req_d     = 1'b0;
      m_wr_d      = 1'b0;
      m_address_d = 8'd0;
      m_dout_d    = 32'd0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      case (state_d)
         S_RD, S_CAP: begin
            m_req_d     = 1'b1;
            m_address_d = src_ptr_d;
            busy_d      = 1'b1;
         end
         S_WR: begin
            m_req_d     = 1'b1;
            m_wr_d      = 1'b1;
            m_address_d = dst_ptr_d;
            m_dout_d    = data_d;
            busy_d      = 1'b1;
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            m_req_d = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         src_ptr_q    <= 8'd0;
         dst_ptr_q    <= 8'd0;
         remain_q     <= 8'd0;
         words_done_q <= 8'd0;
         data_q       <= 32'd0;
         m_req_q      <= 1'b0;
         m_wr_q       <= 1'b0;
         m_address_q  <= 8'd0;
         m_dout_q     <= 32'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_ptr_q    <= src_ptr_d;
         dst_ptr_q    <= dst_ptr_d;
         remain_q     <= remain_d;
         words_done_q <= words_done_d;
         data_q       <= data_d;
         m_req_q      <= m_req_d;
         m_wr_q       <= m_wr_d;
         m_address_q  <= m_address_d;
         m_dout_q     <= m_dout_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign M_req      = m_req_q;
   assign M_wr       = m_wr_q;
   assign M_address  = m_address_q;
   assign M_dout     = m_dout_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign words_done = words_done_q;

endmodule
